change_event_logger: RTL and testbench



---
 rtl/change_event_logger_pkg.sv | 17 +
 rtl/change_event_logger_if.sv | 39 +++
 rtl/change_event_logger_sync_fifo.sv | 50 +++++
 rtl/change_event_logger.sv | 85 ++++++++
 tb/tb_change_event_logger.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/change_event_logger_pkg.sv
// logger_pkg: shared event record type and default sizes for change_event_logger.
// Optional drop counter is enabled by defining CHANGE_LOGGER_DROP_COUNT_EN.
package logger_pkg;
    localparam int LOG_WIDTH = 3;
    localparam int LOG_TS_W  = 16;
    localparam int LOG_DEPTH = 8;

    typedef struct packed {
        logic [LOG_TS_W-1:0]  ts;
        logic [LOG_WIDTH-1:0] prev;
        logic [LOG_WIDTH-1:0] cur;
    } event_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/change_event_logger_if.sv
// change_event_logger_if: sample input and event drain handshake of the change logger.
// Carries drop_count only when CHANGE_LOGGER_DROP_COUNT_EN is defined.
interface change_event_logger_if
    import logger_pkg::*;
#(
    parameter int WIDTH = LOG_WIDTH,
    parameter int DEPTH = LOG_DEPTH,
    parameter int TS_W  = LOG_TS_W
);
    logic [WIDTH-1:0]          sample_in;
    logic                      sample_en;
    logic                      ev_valid;
    logic                      ev_ready;
    logic [TS_W-1:0]           ev_ts;
    logic [WIDTH-1:0]          ev_prev;
    logic [WIDTH-1:0]          ev_cur;
    logic [count_w(DEPTH)-1:0] ev_count;
    logic                      overflow;
    logic                      ovf_clr;
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
    logic [7:0]                drop_count;
`endif

    modport master (
        output sample_in, sample_en, ev_ready, ovf_clr,
        input  ev_valid, ev_ts, ev_prev, ev_cur, ev_count, overflow
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        , drop_count
`endif
    );

    modport slave (
        input  sample_in, sample_en, ev_ready, ovf_clr,
        output ev_valid, ev_ts, ev_prev, ev_cur, ev_count, overflow
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        , drop_count
`endif
    );
endinterface

// File: rtl/change_event_logger_sync_fifo.sv
// sync_fifo: generic DEPTH-entry synchronous FIFO of type T with occupancy count.
// Head reads as zero while empty; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
    import logger_pkg::*;
#(
    parameter type T      = event_t,
    parameter int  DEPTH  = LOG_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = count_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = count == '0;
        full    = count == CW'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/change_event_logger.sv
// change_event_logger: timestamps every change of a sampled bundle into a drainable FIFO.
// Define CHANGE_LOGGER_DROP_COUNT_EN to add a saturating 8-bit drop counter.
module change_event_logger
    import logger_pkg::*;
#(
    parameter int WIDTH = LOG_WIDTH,
    parameter int DEPTH = LOG_DEPTH,
    parameter int TS_W  = LOG_TS_W
) (
    input logic                  clk,
    input logic                  rst,
    change_event_logger_if.slave bus
);
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] cur;
    } ev_t;

    logic [TS_W-1:0]  ts_cnt;
    logic [WIDTH-1:0] last;
    logic             primed;
    logic             change;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    ev_t              head;
    ev_t              entry;

    always_comb begin
        change = bus.sample_en && primed && (bus.sample_in != last);
        pop    = !empty && bus.ev_ready;
        drop   = change && full && !pop;
        entry  = '{ts: ts_cnt, prev: last, cur: bus.sample_in};
    end

    always_ff @(posedge clk) begin
        ts_cnt <= rst ? '0 : ts_cnt + TS_W'(1);
    end

    // The first enabled sample after reset only seeds the reference value.
    always_ff @(posedge clk) begin
        if (rst) begin
            primed <= 1'b0;
            last   <= '0;
        end else if (bus.sample_en) begin
            primed <= 1'b1;
            last   <= bus.sample_in;
        end
    end

    sync_fifo #(.T(ev_t), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.ev_count)
    );

    assign bus.ev_valid = !empty;
    assign bus.ev_ts    = head.ts;
    assign bus.ev_prev  = head.prev;
    assign bus.ev_cur   = head.cur;

    // A drop in the same cycle as a clear still leaves overflow set.
    always_ff @(posedge clk) begin
        bus.overflow <= rst ? 1'b0 : drop ? 1'b1 : bus.ovf_clr ? 1'b0 : bus.overflow;
    end

`ifdef CHANGE_LOGGER_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            bus.drop_count <= '0;
        else if (bus.ovf_clr)
            bus.drop_count <= {7'd0, drop};
        else if (drop && bus.drop_count != 8'hff)
            bus.drop_count <= bus.drop_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_change_event_logger.sv
// tb_change_event_logger: directed table plus hand sequences for change_event_logger.
module tb_change_event_logger;
    import logger_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_event_logger_if #(.TS_W(16)) bus ();
    change_event_logger_if #(.TS_W(4))  bus_s ();

    change_event_logger #(.TS_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
    change_event_logger #(.TS_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    typedef struct packed {
        logic        en;
        logic [2:0]  in;
        logic        rdy;
        logic        clr;
        logic        v;
        logic [15:0] ts;
        logic [2:0]  prev;
        logic [2:0]  cur;
        logic [3:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t tbl [14];
    int   checks   = 0;
    int   failures = 0;
    int   tnow     = 0;
    int   t0;
    int   tp;
    int   tr;

    function automatic vec_t mk(input logic en, input logic [2:0] in, input logic rdy,
                                input logic v, input int ts, input logic [2:0] p,
                                input logic [2:0] c, input int cnt);
        return '{en: en, in: in, rdy: rdy, clr: 1'b0, v: v, ts: 16'(ts), prev: p,
                 cur: c, cnt: 4'(cnt), ovf: 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        tnow++;
    endtask

    task automatic drive(input logic en, input logic [2:0] in, input logic rdy, input logic clr);
        bus.sample_en = en;
        bus.sample_in = in;
        bus.ev_ready  = rdy;
        bus.ovf_clr   = clr;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_head(input string nm, input int ts, input logic [2:0] p, input logic [2:0] c);
        chk(nm, {bus.ev_valid, bus.ev_ts, bus.ev_prev, bus.ev_cur}, {1'b1, 16'(ts), p, c});
    endtask

    initial begin
        drive(0, 3'b000, 0, 0);
        bus_s.sample_en = 0;
        bus_s.sample_in = 3'b000;
        bus_s.ev_ready  = 0;
        bus_s.ovf_clr   = 0;

        // row i is sampled at the edge where the counter reads i
        tbl[0]  = mk(0, 3'b000, 0, 0, 0,  3'b000, 3'b000, 0);
        tbl[1]  = mk(1, 3'b010, 0, 0, 0,  3'b000, 3'b000, 0);
        tbl[2]  = mk(1, 3'b010, 0, 0, 0,  3'b000, 3'b000, 0);
        tbl[3]  = mk(0, 3'b111, 0, 0, 0,  3'b000, 3'b000, 0);
        tbl[4]  = mk(0, 3'b000, 0, 0, 0,  3'b000, 3'b000, 0);
        tbl[5]  = mk(1, 3'b011, 1, 1, 5,  3'b010, 3'b011, 1);
        tbl[6]  = mk(1, 3'b011, 1, 0, 0,  3'b000, 3'b000, 0);
        tbl[7]  = mk(1, 3'b001, 0, 1, 7,  3'b011, 3'b001, 1);
        tbl[8]  = mk(0, 3'b001, 0, 1, 7,  3'b011, 3'b001, 1);
        tbl[9]  = mk(0, 3'b001, 0, 1, 7,  3'b011, 3'b001, 1);
        tbl[10] = mk(0, 3'b001, 0, 1, 7,  3'b011, 3'b001, 1);
        tbl[11] = mk(0, 3'b001, 0, 1, 7,  3'b011, 3'b001, 1);
        tbl[12] = mk(1, 3'b000, 1, 1, 12, 3'b001, 3'b000, 1);
        tbl[13] = mk(0, 3'b000, 1, 0, 0,  3'b000, 3'b000, 0);

        tick();
        tnow = 0;
        chk("reset", {bus.ev_valid, bus.ev_ts, bus.ev_prev, bus.ev_cur, bus.ev_count, bus.overflow}, 64'd0);
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        chk("reset_drop_count", bus.drop_count, 0);
`endif
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].en, tbl[i].in, tbl[i].rdy, tbl[i].clr);
            tick();
            chk($sformatf("vec%0d", i),
                {bus.ev_valid, bus.ev_ts, bus.ev_prev, bus.ev_cur, bus.ev_count, bus.overflow},
                {tbl[i].v, tbl[i].ts, tbl[i].prev, tbl[i].cur, tbl[i].cnt, tbl[i].ovf});
        end

        // ten back-to-back toggles of bit 0 with the consumer stalled
        t0 = tnow;
        for (int k = 0; k < 10; k++) begin
            drive(1, {2'b00, ~k[0]}, 0, 0);
            tick();
        end
        chk("ovf_count", bus.ev_count, 8);
        chk("ovf_flag", bus.overflow, 1);
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        chk("ovf_drop_count", bus.drop_count, 2);
`endif
        drive(0, 3'b000, 0, 1);
        tick();
        chk("ovf_clr", bus.overflow, 0);
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        chk("clr_drop_count", bus.drop_count, 0);
`endif
        chk_head("ovf_head0", t0, 3'b000, 3'b001);

        // full FIFO: change and pop together must not drop
        tp = tnow;
        drive(1, 3'b001, 1, 0);
        tick();
        chk("full_pushpop_count", bus.ev_count, 8);
        chk("full_pushpop_ovf", bus.overflow, 0);
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        chk("full_pushpop_drop", bus.drop_count, 0);
`endif
        for (int k = 1; k < 8; k++) begin
            chk_head($sformatf("drain%0d", k), t0 + k, k[0] ? 3'b001 : 3'b000, k[0] ? 3'b000 : 3'b001);
            drive(0, 3'b001, 1, 0);
            tick();
        end
        chk_head("drain_last", tp, 3'b000, 3'b001);
        tick();
        chk("drained", {bus.ev_valid, bus.ev_count}, 0);

        // refill, then drop while clearing: the set must win
        for (int j = 0; j < 8; j++) begin
            drive(1, j[0] ? 3'b001 : 3'b000, 0, 0);
            tick();
        end
        chk("refill_count", bus.ev_count, 8);
        drive(1, 3'b000, 0, 1);
        tick();
        chk("clr_vs_drop", bus.overflow, 1);
`ifdef CHANGE_LOGGER_DROP_COUNT_EN
        chk("clr_vs_drop_count", bus.drop_count, 1);
`endif
        for (int j = 0; j < 3; j++) begin
            drive(0, 3'b000, 1, 0);
            tick();
        end
        chk("five_queued", bus.ev_count, 5);

        // reset with events queued flushes and forces re-priming
        drive(0, 3'b000, 0, 0);
        rst = 1;
        tick();
        tnow = 0;
        chk("mid_rst", {bus.ev_valid, bus.ev_ts, bus.ev_prev, bus.ev_cur, bus.ev_count, bus.overflow}, 64'd0);
        rst = 0;
        drive(1, 3'b101, 0, 0);
        tick();
        chk("reprime", {bus.ev_valid, bus.ev_count}, 0);
        tick();
        chk("reprime_same", {bus.ev_valid, bus.ev_count}, 0);
        tr = tnow;
        drive(1, 3'b100, 0, 0);
        tick();
        chk_head("post_rst_event", tr, 3'b101, 3'b100);
        chk("post_rst_count", bus.ev_count, 1);

        // 4-bit timestamp instance: changes at counter 15 and 0
        drive(0, 3'b000, 0, 0);
        rst = 1;
        tick();
        tnow = 0;
        rst = 0;
        bus_s.sample_en = 1;
        bus_s.sample_in = 3'b000;
        tick();
        bus_s.sample_en = 0;
        while (tnow != 15) tick();
        bus_s.sample_en = 1;
        bus_s.sample_in = 3'b001;
        tick();
        bus_s.sample_in = 3'b000;
        tick();
        bus_s.sample_en = 0;
        chk("wrap_count", bus_s.ev_count, 2);
        chk("wrap_ts15", {bus_s.ev_valid, bus_s.ev_ts, bus_s.ev_prev, bus_s.ev_cur}, {1'b1, 4'd15, 3'b000, 3'b001});
        bus_s.ev_ready = 1;
        tick();
        chk("wrap_ts0", {bus_s.ev_valid, bus_s.ev_ts, bus_s.ev_prev, bus_s.ev_cur}, {1'b1, 4'd0, 3'b001, 3'b000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
